wb_host_master: RTL and testbench

Wishbone classic single-transfer initiator, the opposite end of the `wbs_*` responder port on the user project. It accepts one command at a time from an on-chip requester (RISC-V core load/store unit or debug bridge) over a valid/ready handshake. It runs a Wishbone B4 classic cycle toward a responder and returns read data and a completion status over a second valid/ready handshake. An optional watchdog aborts transfers whose responder never acknowledges.

---
 rtl/wb_host_pkg.sv | 17 +
 rtl/wb_host_watchdog.sv | 32 +++
 rtl/wb_host_master.sv | 120 ++++++++++++
 tb/tb_wb_host_master.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone classic single-transfer host.
// Optional watchdog is controlled by the WB_HOST_TIMEOUT_EN macro.
package wb_host_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } wb_state_e;

  localparam logic [1:0] WB_ST_OK      = 2'd0;
  localparam logic [1:0] WB_ST_ERR     = 2'd1;
  localparam logic [1:0] WB_ST_TIMEOUT = 2'd2;

  localparam int unsigned WB_CNT_W = 16;

endpackage

// File: rtl/wb_host_watchdog.sv
// Saturating bus-cycle counter; expired flags the cycle the count equals Limit.
// Built only when WB_HOST_TIMEOUT_EN is defined.
module wb_host_watchdog
  import wb_host_pkg::*;
#(
  parameter int unsigned Limit = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [WB_CNT_W-1:0] LimitW = WB_CNT_W'(Limit);

  logic [WB_CNT_W-1:0] count_q;

  // Clear on bus entry, count each active cycle, hold at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_o = enable_i && (count_q == LimitW);

endmodule

// File: rtl/wb_host_master.sv
// Wishbone B4 classic single-transfer initiator with valid/ready command and
// response ports. Define WB_HOST_TIMEOUT_EN to build the no-ack watchdog.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [DW-1:0] cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_dat_o,
  output logic [1:0]    rsp_status_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic [DW-1:0] wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic [DW-1:0] wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i
);

  wb_state_e state_q;
  logic      cmd_fire;
  logic      timeout_hit;

  assign cmd_fire = (state_q == StIdle) && cmd_valid_i;

`ifdef WB_HOST_TIMEOUT_EN
  wb_host_watchdog #(
    .Limit(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_ni),
    .clear_i  (cmd_fire),
    .enable_i (state_q == StBus),
    .expired_o(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Control FSM; every port output is a register updated here.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q      <= StIdle;
      cmd_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_status_o <= WB_ST_OK;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      wbm_we_o     <= 1'b0;
      wbm_adr_o    <= '0;
      wbm_dat_o    <= '0;
      wbm_sel_o    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            state_q     <= StBus;
            cmd_ready_o <= 1'b0;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            wbm_we_o    <= cmd_we_i;
            wbm_adr_o   <= cmd_adr_i;
            wbm_dat_o   <= cmd_dat_i;
            wbm_sel_o   <= cmd_sel_i;
          end
        end
        StBus: begin
          // Priority: err over ack, ack over a watchdog expiring the same cycle.
          if (wbm_err_i) begin
            state_q      <= StResp;
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= WB_ST_ERR;
            rsp_dat_o    <= '0;
          end else if (wbm_ack_i) begin
            state_q      <= StResp;
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= WB_ST_OK;
            rsp_dat_o    <= wbm_we_o ? '0 : wbm_dat_i;
          end else if (timeout_hit) begin
            state_q      <= StResp;
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= WB_ST_TIMEOUT;
            rsp_dat_o    <= '0;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            state_q     <= StIdle;
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Directed, table-driven bench for wb_host_master (TIMEOUT_CYCLES = 8).
module tb_wb_host_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [DW-1:0] cmd_dat = '0;
  logic [3:0]    cmd_sel = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_dat;
  logic [1:0]    rsp_status;
  logic          wbm_cyc, wbm_stb, wbm_we;
  logic [AW-1:0] wbm_adr;
  logic [DW-1:0] wbm_dat_out;
  logic [3:0]    wbm_sel;
  logic [DW-1:0] wbm_dat_in = '0;
  logic          wbm_ack = 1'b0;
  logic          wbm_err = 1'b0;

  int errors = 0;
  int checks = 0;

  wb_host_master #(
    .AW(AW),
    .DW(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_status_o(rsp_status),
    .wbm_cyc_o   (wbm_cyc),
    .wbm_stb_o   (wbm_stb),
    .wbm_we_o    (wbm_we),
    .wbm_adr_o   (wbm_adr),
    .wbm_dat_o   (wbm_dat_out),
    .wbm_sel_o   (wbm_sel),
    .wbm_dat_i   (wbm_dat_in),
    .wbm_ack_i   (wbm_ack),
    .wbm_err_i   (wbm_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic [1:0]  exp_status;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input vec_t v);
    chk({tag, " cyc"}, 32'(wbm_cyc), 32'd1);
    chk({tag, " stb"}, 32'(wbm_stb), 32'd1);
    chk({tag, " we"}, 32'(wbm_we), 32'(v.we));
    chk({tag, " adr"}, wbm_adr, v.adr);
    chk({tag, " dat"}, wbm_dat_out, v.dat);
    chk({tag, " sel"}, 32'(wbm_sel), 32'(v.sel));
  endtask

  // Drive one transfer end to end; caller is just after an edge in IDLE.
  task automatic run_txn(input vec_t v);
    chk("idle cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we = v.we;
    cmd_adr = v.adr;
    cmd_dat = v.dat;
    cmd_sel = v.sel;
    tick();
    cmd_valid = 1'b0;
    cmd_we = ~v.we;
    cmd_adr = 32'hFFFF_FFFF;
    cmd_dat = 32'h5555_AAAA;
    cmd_sel = ~v.sel;
    chk_bus("bus start", v);
    chk("bus cmd_ready", 32'(cmd_ready), 32'd0);
    for (int w = 0; w <= v.waits; w++) begin
      if (w == v.waits) begin
        wbm_ack = v.ack;
        wbm_err = v.err;
        wbm_dat_in = v.rdata;
      end else begin
        wbm_ack = 1'b0;
        wbm_err = 1'b0;
        wbm_dat_in = 32'h1111_2222;
      end
      tick();
      if (w < v.waits) chk_bus("bus wait", v);
    end
    wbm_ack = 1'b0;
    wbm_err = 1'b0;
    chk("end cyc", 32'(wbm_cyc), 32'd0);
    chk("end stb", 32'(wbm_stb), 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_status", 32'(rsp_status), 32'(v.exp_status));
    chk("rsp_dat", rsp_dat, v.exp_dat);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp consumed", 32'(rsp_valid), 32'd0);
    chk("ready back", 32'(cmd_ready), 32'd1);
    chk("adr held", wbm_adr, v.adr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global time limit: got timeout expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t v;
    int cyc_cnt;

    vecs[0] = '{1'b0, 32'h1000_0000, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h3000_0004, 32'h1234_5678, 4'h3, 4, 1'b1, 1'b0, 32'h9999_9999, 2'd0, 32'h0};
    vecs[2] = '{1'b0, 32'h2000_0010, 32'h0, 4'hF, 1, 1'b1, 1'b1, 32'hCAFE_F00D, 2'd1, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_0008, 32'hAAAA_0001, 4'h0, 0, 1'b1, 1'b0, 32'h7777_7777, 2'd0, 32'h0};
    vecs[4] = '{1'b0, 32'h4000_0000, 32'h0, 4'hC, 2, 1'b0, 1'b1, 32'h1234_0000, 2'd1, 32'h0};
    vecs[5] = '{1'b0, 32'h5000_0020, 32'h0, 4'h1, 3, 1'b1, 1'b0, 32'hA5A5_5A5A, 2'd0, 32'hA5A5_5A5A};
    // Ack arrives on the very cycle the watchdog would expire: ack must win.
    vecs[6] = '{1'b0, 32'h6000_0000, 32'h0, 4'hF, 8, 1'b1, 1'b0, 32'h0BAD_F00D, 2'd0, 32'h0BAD_F00D};

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset cyc", 32'(wbm_cyc), 32'd0);
    chk("reset adr", wbm_adr, 32'd0);
    chk("reset status", 32'(rsp_status), 32'd0);

    // Ack/err while idle must be ignored.
    wbm_ack = 1'b1;
    wbm_err = 1'b1;
    tick();
    wbm_ack = 1'b0;
    wbm_err = 1'b0;
    chk("idle ack ignored", 32'(rsp_valid), 32'd0);
    chk("idle cyc", 32'(wbm_cyc), 32'd0);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Response back-pressure with a second command waiting.
    v = vecs[0];
    cmd_valid = 1'b1;
    cmd_we = 1'b0;
    cmd_adr = 32'h7000_0000;
    cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    wbm_ack = 1'b1;
    wbm_dat_in = 32'h0F0F_1234;
    tick();
    wbm_ack = 1'b0;
    cmd_valid = 1'b1;
    cmd_we = 1'b1;
    cmd_adr = 32'h7000_0040;
    cmd_dat = 32'h0000_BEEF;
    cmd_sel = 4'h2;
    for (int i = 0; i < 10; i++) begin
      wbm_dat_in = 32'(i);
      tick();
      chk("hold valid", 32'(rsp_valid), 32'd1);
      chk("hold dat", rsp_dat, 32'h0F0F_1234);
      chk("hold cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold no cyc", 32'(wbm_cyc), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("release ready", 32'(cmd_ready), 32'd1);
    chk("release valid", 32'(rsp_valid), 32'd0);
    tick();
    cmd_valid = 1'b0;
    v = '{1'b1, 32'h7000_0040, 32'h0000_BEEF, 4'h2, 0, 1'b1, 1'b0, 32'h0, 2'd0, 32'h0};
    chk_bus("queued cmd", v);
    wbm_ack = 1'b1;
    tick();
    wbm_ack = 1'b0;
    chk("queued rsp", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // No-ack behaviour: watchdog timeout or indefinite wait.
    cmd_valid = 1'b1;
    cmd_we = 1'b0;
    cmd_adr = 32'h8000_0000;
    tick();
    cmd_valid = 1'b0;
    cyc_cnt = 0;
    for (int i = 0; i < 40 && wbm_cyc; i++) begin
      cyc_cnt++;
      tick();
    end
`ifdef WB_HOST_TIMEOUT_EN
    chk("timeout cyc cycles", 32'(cyc_cnt), 32'(TO + 1));
    chk("timeout valid", 32'(rsp_valid), 32'd1);
    chk("timeout status", 32'(rsp_status), 32'd2);
    chk("timeout dat", rsp_dat, 32'd0);
    tick();
    wbm_ack = 1'b1;
    wbm_dat_in = 32'hFEED_FACE;
    tick();
    wbm_ack = 1'b0;
    tick();
    chk("late ack status", 32'(rsp_status), 32'd2);
    chk("late ack dat", rsp_dat, 32'd0);
    chk("late ack cyc", 32'(wbm_cyc), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`else
    chk("no watchdog cyc held", 32'(cyc_cnt), 32'd40);
    chk("no watchdog no rsp", 32'(rsp_valid), 32'd0);
    wbm_ack = 1'b1;
    wbm_dat_in = 32'hFEED_FACE;
    tick();
    wbm_ack = 1'b0;
    chk("late ok status", 32'(rsp_status), 32'd0);
    chk("late ok dat", rsp_dat, 32'hFEED_FACE);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`endif
    chk("after noack ready", 32'(cmd_ready), 32'd1);

    // Reset asserted in the middle of a bus cycle.
    cmd_valid = 1'b1;
    cmd_we = 1'b1;
    cmd_adr = 32'h9000_0000;
    cmd_dat = 32'h1357_9BDF;
    cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("pre-reset cyc", 32'(wbm_cyc), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid reset cyc", 32'(wbm_cyc), 32'd0);
    chk("mid reset stb", 32'(wbm_stb), 32'd0);
    chk("mid reset we", 32'(wbm_we), 32'd0);
    chk("mid reset adr", wbm_adr, 32'd0);
    chk("mid reset dat", wbm_dat_out, 32'd0);
    chk("mid reset sel", 32'(wbm_sel), 32'd0);
    chk("mid reset cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid reset rsp_dat", rsp_dat, 32'd0);
    wbm_ack = 1'b1;
    tick();
    wbm_ack = 1'b0;
    tick();
    chk("post reset no rsp", 32'(rsp_valid), 32'd0);
    chk("post reset status", 32'(rsp_status), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
